// File: rtl/bru_pq.sv
// -----------------------------------------------------------------------------
// bru_pq : branch resolution unit with an in-order prediction queue.
//
// Fetch pushes one {pc, taken, target} record per predicted conditional
// branch. Execute resolves branches in program order; each outcome is checked
// against the oldest record. On a mismatch the unit registers a one-cycle
// flush with the corrected next PC and drops every younger (wrong-path)
// record. Prediction statistics are kept for the performance counters.
//
// Ports
//   clk, clr            clock (rising edge) / asynchronous active-high reset
//   pq_push             fetch pushes one prediction record
//   pq_pc               PC of the predicted branch
//   pq_taken            predicted direction (1 = taken)
//   pq_target           predicted taken target
//   pq_full, pq_empty   queue occupancy status (combinational from state)
//   rs_valid            execute resolves the oldest branch this cycle
//   rs_taken            actual direction
//   rs_target           actual taken target
//   flush               registered one-cycle mispredict pulse
//   redirect_pc         correct next PC, valid while flush=1
//   rs_err              sticky: a resolve arrived while the queue was empty
//   n_resolved          resolved-branch counter (wraps)
//   n_mispred           mispredicted-branch counter (wraps)
// -----------------------------------------------------------------------------
module bru_pq #(
   parameter int DEPTH = 4,
   parameter int CNTW  = 32
) (
   input  logic            clk,
   input  logic            clr,
   input  logic            pq_push,
   input  logic [63:0]     pq_pc,
   input  logic            pq_taken,
   input  logic [63:0]     pq_target,
   output logic            pq_full,
   output logic            pq_empty,
   input  logic            rs_valid,
   input  logic            rs_taken,
   input  logic [63:0]     rs_target,
   output logic            flush,
   output logic [63:0]     redirect_pc,
   output logic            rs_err,
   output logic [CNTW-1:0] n_resolved,
   output logic [CNTW-1:0] n_mispred
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   localparam logic [PW-1:0]   PTR_ONE  = PW'(1);
   localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
   localparam logic [CW-1:0]   CNT_FULL = CW'(DEPTH);
   localparam logic [CNTW-1:0] STAT_ONE = CNTW'(1);

   // record storage (no reset needed: only entries between head and tail are read)
   logic [63:0] pc_q     [DEPTH];
   logic        taken_q  [DEPTH];
   logic [63:0] target_q [DEPTH];

   logic [PW-1:0]   head_q, head_d;
   logic [PW-1:0]   tail_q, tail_d;
   logic [CW-1:0]   cnt_q,  cnt_d;
   logic            flush_q, flush_d;
   logic [63:0]     redir_q, redir_d;
   logic            err_q,   err_d;
   logic [CNTW-1:0] nres_q,  nres_d;
   logic [CNTW-1:0] nmis_q,  nmis_d;

   logic        full, empty;
   logic        rs_fire, mispred, correct, push_ok;
   logic [63:0] hd_pc, hd_target;
   logic        hd_taken;

   assign full  = (cnt_q == CNT_FULL);
   assign empty = (cnt_q == '0);

   assign hd_pc     = pc_q[head_q];
   assign hd_taken  = taken_q[head_q];
   assign hd_target = target_q[head_q];

   // A resolve only counts when there is a record to check it against.
   assign rs_fire = rs_valid & ~empty;

   // Target only matters when both sides agree the branch was taken.
   assign mispred = rs_fire &
                    ((rs_taken != hd_taken) |
                     (rs_taken & hd_taken & (rs_target != hd_target)));
   assign correct = rs_fire & ~mispred;

   // A correct resolve frees the head slot in the same cycle, so a push into
   // a full queue is still accepted then. A push alongside a mispredict is
   // wrong-path and is dropped.
   assign push_ok = pq_push & (~full | correct) & ~mispred;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      cnt_d   = cnt_q;
      flush_d = 1'b0;
      redir_d = redir_q;
      err_d   = err_q;
      nres_d  = nres_q;
      nmis_d  = nmis_q;

      if (rs_valid && empty) begin
         err_d = 1'b1;
      end

      if (mispred) begin
         // Squash everything: the queue restarts empty at slot 0.
         head_d  = '0;
         tail_d  = '0;
         cnt_d   = '0;
         flush_d = 1'b1;
         redir_d = rs_taken ? rs_target : (hd_pc + 64'd4);
         nres_d  = nres_q + STAT_ONE;
         nmis_d  = nmis_q + STAT_ONE;
      end else begin
         if (correct) begin
            head_d = head_q + PTR_ONE;
            nres_d = nres_q + STAT_ONE;
         end
         if (push_ok) begin
            tail_d = tail_q + PTR_ONE;
         end
         case ({push_ok, correct})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         head_q  <= '0;
         tail_q  <= '0;
         cnt_q   <= '0;
         flush_q <= 1'b0;
         redir_q <= '0;
         err_q   <= 1'b0;
         nres_q  <= '0;
         nmis_q  <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         cnt_q   <= cnt_d;
         flush_q <= flush_d;
         redir_q <= redir_d;
         err_q   <= err_d;
         nres_q  <= nres_d;
         nmis_q  <= nmis_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         pc_q[tail_q]     <= pq_pc;
         taken_q[tail_q]  <= pq_taken;
         target_q[tail_q] <= pq_target;
      end
   end

   assign pq_full     = full;
   assign pq_empty    = empty;
   assign flush       = flush_q;
   assign redirect_pc = redir_q;
   assign rs_err      = err_q;
   assign n_resolved  = nres_q;
   assign n_mispred   = nmis_q;

endmodule

// File: doc/bru_pq.md
Name: bru_pq

Overview:
- Branch resolution unit with an in-order prediction queue. It is the consumer side of the static predictor.
- Fetch pushes one record per predicted conditional branch. Execute resolves branches in program order.
- The block compares each actual outcome with the oldest record. On a mismatch it produces a one-cycle flush and a redirect PC toward fetch.
- It also keeps prediction statistics for the performance counters.

Parameters:
- DEPTH, 4, number of in-flight branch records; must be a power of two and at least 2.
- CNTW, 32, width of the statistics counters.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- clr  input  1  asynchronous active-high reset.
- pq_push  input  1  fetch pushes one prediction record.
- pq_pc  input  64  PC of the predicted branch.
- pq_taken  input  1  predicted direction (1 = taken).
- pq_target  input  64  predicted target (pc + sign-extended B-offset).
- pq_full  output  1  queue holds DEPTH records; fetch must stall branch pushes.
- pq_empty  output  1  queue holds no records.
- rs_valid  input  1  execute resolves the oldest branch this cycle.
- rs_taken  input  1  actual direction.
- rs_target  input  64  actual taken target.
- flush  output  1  registered one-cycle mispredict pulse.
- redirect_pc  output  64  correct next PC; valid while flush=1.
- rs_err  output  1  sticky flag: a resolve arrived while the queue was empty.
- n_resolved  output  CNTW  count of resolved branches.
- n_mispred  output  CNTW  count of mispredicted branches.

Behaviour:
- Reset (async, clr=1): pointers and count are 0, pq_empty=1, pq_full=0, flush=0, redirect_pc=0, rs_err=0, both counters 0. Any in-progress operation is abandoned immediately.
- Storage: circular buffer, DEPTH entries of {pc, taken, target}.
  - Head and tail pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Occupancy counter is log2(DEPTH)+1 bits.
- pq_full = (count==DEPTH). pq_empty = (count==0). Both are combinational from registered state.
- Push:
  - Accepted when pq_push=1 and pq_full=0. The entry is written at the tail and the tail advances.
  - A push while full is dropped with no state change.
- Resolve:
  - Applies when rs_valid=1 and pq_empty=0. The head entry is compared combinationally.
  - Mispredict is (rs_taken != head.taken), or (rs_taken && head.taken && rs_target != head.target).
  - Correct path: head advances and n_resolved increments.
  - Mispredict path, on the same edge:
    - n_resolved and n_mispred both increment.
    - flush is registered to 1 for exactly the next cycle.
    - redirect_pc is registered to rs_target if rs_taken, otherwise head.pc + 4 (64-bit wrap).
    - Head, tail and count are all cleared, which discards younger wrong-path records.
  - Resolve while empty: no queue change, no counter change, rs_err is set and stays set until reset.
- Simultaneous push and resolve:
  - Correct resolve: both apply and count is unchanged. This is legal even when the queue is full, because the resolve frees the head slot in the same cycle; that push is accepted.
  - Mispredicting resolve: the push is discarded, since it is wrong-path. The queue ends empty.
- flush deasserts after one cycle unless another mispredict is registered. redirect_pc holds its last value otherwise.
- Counters wrap modulo 2^CNTW without saturation.
- Latency: the flush and redirect_pc outputs appear 1 cycle after the resolving edge. The queue becomes visible as empty on the cycle after a mispredict.

Test Plan:
- Reset mid-operation: push 3 records, assert clr for one cycle → pq_empty=1, counters=0, flush=0, rs_err=0 immediately, without waiting for a clock edge.
- Correct resolve, not taken: push {pc=0x1000, taken=0, target=0x0FF0}, resolve rs_taken=0 → no flush, n_resolved=1, n_mispred=0, pq_empty=1.
- Direction mispredict:
  - Push {0x2000, taken=1, target=0x1F00} and a younger record, then resolve rs_taken=0.
  - Required: flush=1 for one cycle, redirect_pc=0x2004, queue empty, n_mispred=1.
- Target mispredict:
  - Push {0x3000, 1, 0x2F00}, resolve rs_taken=1, rs_target=0x2E00.
  - Required: flush=1, redirect_pc=0x2E00.
- Full and wrap:
  - Push 4 records → pq_full=1. A 5th push is dropped.
  - Then resolve (correct) together with a push, repeated 6 times. Required: pq_full stays 1, FIFO order is preserved across pointer wrap, n_resolved=6.
- Empty resolve and simultaneous mispredict+push:
  - rs_valid on an empty queue → rs_err=1 and sticky.
  - Mispredicting resolve with pq_push=1 → pq_empty=1 next cycle, pushed record discarded.
